// File: rtl/p2s_pkg.sv
// p2s_pkg: shared default word width and serializer FSM state type
package p2s_pkg;
  localparam int P2S_DATA_WIDTH = 8;
  typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/parallel_to_serial_if.sv
// parallel_to_serial_if: load handshake (load_valid/load_ready/data_in), shift_hold stall, serial stream and status; master=producer side, slave=serializer
interface parallel_to_serial_if import p2s_pkg::*; #(parameter int DATA_WIDTH = P2S_DATA_WIDTH) ();
  logic                  load_valid;
  logic                  load_ready;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  shift_hold;
  logic                  serial_out;
  logic                  shift_enable;
  logic                  frame_done;
  logic                  busy;
  modport master (output load_valid, data_in, shift_hold, input load_ready, serial_out, shift_enable, frame_done, busy);
  modport slave  (input load_valid, data_in, shift_hold, output load_ready, serial_out, shift_enable, frame_done, busy);
endinterface

// File: rtl/p2s_hold_reg.sv
// p2s_hold_reg: one-entry word buffer; i_load writes i_data and sets o_full, i_clear empties it, o_data holds the buffered word
module p2s_hold_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic                  i_clear,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_full,
  output logic [DATA_WIDTH-1:0] o_data
);
  logic                  r_full;
  logic [DATA_WIDTH-1:0] r_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_load) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end
  end
  assign o_full = r_full;
  assign o_data = r_data;
endmodule

// File: rtl/parallel_to_serial.sv
// parallel_to_serial: buffered word-to-bit serializer; ports clk, rst, bus (slave: load handshake in, serial_out/shift_enable/frame_done/busy out)
module parallel_to_serial import p2s_pkg::*; #(
  parameter int DATA_WIDTH = P2S_DATA_WIDTH,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  parallel_to_serial_if.slave bus
);
  localparam int CW = $clog2(DATA_WIDTH);
  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_sr;
  logic [DATA_WIDTH-1:0] w_buf;
  logic                  w_full;
  logic                  w_head;
  logic                  w_shift;
  logic                  w_done;
  logic                  w_xfer;
  p2s_hold_reg #(.DATA_WIDTH(DATA_WIDTH)) u_hold (
    .clk     (clk),
    .rst     (rst),
    .i_load  (bus.load_valid && !w_full),
    .i_clear (w_xfer),
    .i_data  (bus.data_in),
    .o_full  (w_full),
    .o_data  (w_buf)
  );
  // a full buffer refills the shift register on the last-bit edge so frames run back to back
  always_comb begin
    w_head  = MSB_FIRST ? r_sr[DATA_WIDTH-1] : r_sr[0];
    w_shift = (r_state == SHIFT) && !bus.shift_hold;
    w_done  = w_shift && (r_cnt == CW'(DATA_WIDTH - 1));
    w_xfer  = w_full && ((r_state == IDLE) || w_done);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sr    <= '0;
    end else if (w_xfer) begin
      r_sr    <= w_buf;
      r_cnt   <= '0;
      r_state <= SHIFT;
    end else if (w_done) begin
      r_cnt   <= '0;
      r_state <= IDLE;
    end else if (w_shift) begin
      r_sr    <= MSB_FIRST ? (r_sr << 1) : (r_sr >> 1);
      r_cnt   <= r_cnt + 1'b1;
    end
  end
  assign bus.load_ready   = !w_full;
  assign bus.serial_out   = (r_state == SHIFT) && w_head;
  assign bus.shift_enable = w_shift;
  assign bus.frame_done   = w_done;
  assign bus.busy         = (r_state == SHIFT) || w_full;
endmodule

// File: doc/parallel_to_serial.md
PARALLEL_TO_SERIAL -- requirements
Module: parallel_to_serial

Interface
REQ-001 Parameter DATA_WIDTH, default 8: word width in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = bit DATA_WIDTH-1 is sent first; 0 = bit 0 is sent first.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 load_valid  input  1  data_in holds a word to serialize.
REQ-006 load_ready  output  1  the block can accept a word this cycle.
REQ-007 data_in  input  DATA_WIDTH  parallel word; sampled only on accept.
REQ-008 shift_hold  input  1  downstream stall request; freezes shifting.
REQ-009 serial_out  output  1  current serial bit; drives the downstream serial_in.
REQ-010 shift_enable  output  1  serial_out is valid and the downstream shifts this cycle.
REQ-011 frame_done  output  1  asserted during the cycle the last bit of a word is shifted.
REQ-012 busy  output  1  state is SHIFT or the holding buffer is full.

Function
REQ-013 Accept occurs when load_valid and load_ready are both 1 at a rising edge; data_in is then written into a one-entry holding buffer.
REQ-014 load_ready equals the inverse of the holding-buffer full flag; it has no combinational path from load_valid or shift_hold.
REQ-015 States: IDLE and SHIFT; an internal bit counter runs 0..DATA_WIDTH-1.
REQ-016 In IDLE with the buffer full:
- the next edge moves the buffer into the shift register;
- the buffer is cleared, the counter is set to 0 and the state becomes SHIFT.
REQ-017 Latency: a word accepted at edge k gives the first shift_enable in the cycle following edge k+1.
REQ-018 In SHIFT with shift_hold=0:
- shift_enable=1 and serial_out is the current head bit (selected per MSB_FIRST);
- the next edge shifts the register by one and increments the counter.
REQ-019 In SHIFT with shift_hold=1:
- shift_enable=0 and serial_out holds the current head bit;
- the counter, shift register and state do not change.
REQ-020 frame_done = shift_enable AND (counter == DATA_WIDTH-1).
REQ-021 On the frame_done edge, if the buffer is full:
- the buffer loads the shift register, the counter is set to 0 and the state stays SHIFT;
- the result is back-to-back words with no idle bubble.
REQ-022 On the frame_done edge, if the buffer is empty, the state becomes IDLE.
REQ-023 An accept on the same edge as a buffer-to-shift transfer is impossible, because load_ready is 0 while the buffer is full; no word is ever overwritten or lost.
REQ-024 Outside SHIFT, serial_out=0, shift_enable=0 and frame_done=0.
REQ-025 shift_hold is ignored in IDLE; a held SHIFT may be held indefinitely.
REQ-026 Exactly DATA_WIDTH shift_enable pulses are issued per accepted word.

Reset
REQ-027 While rst=1 at an edge:
- state goes to IDLE, the counter to 0, the shift register to 0 and the buffer flag to empty.
REQ-028 Output values after reset: load_ready=1, serial_out=0, shift_enable=0, frame_done=0, busy=0.
REQ-029 A reset asserted mid-frame discards both the partial word and any buffered word; no further shift_enable is issued for them.
REQ-030 An accept coincident with rst=1 is discarded.

Structure
REQ-031 A shared package p2s_pkg holds the DATA_WIDTH default constant and the state enum typedef (IDLE, SHIFT).
REQ-032 The holding buffer (data register, full flag and load/clear controls) is one sub-module, p2s_hold_reg; the FSM, counter and shift register stay in the top module.
REQ-033 Counter width = clog2(DATA_WIDTH); no counter wrap is permitted beyond DATA_WIDTH-1.

Verification
REQ-034 Reset, then accept 8'hA5 with MSB_FIRST=1 and no hold -> serial_out is 1,0,1,0,0,1,0,1 on 8 consecutive shift_enable cycles; frame_done is on the 8th; then IDLE.
REQ-035 With MSB_FIRST=0, accept 8'h01 -> bit sequence 1,0,0,0,0,0,0,0.
REQ-036 Accept 8'hF0 and, while it shifts, accept 8'h0F -> 16 contiguous shift_enable cycles; load_ready is 0 from the second accept until its transfer.
REQ-037 Assert shift_hold for 3 cycles after bit 3 of 8'hC3 -> shift_enable=0 and serial_out stable for those 3 cycles; the full sequence 1,1,0,0,0,0,1,1 resumes intact.
REQ-038 Assert rst after bit 4 of 8'hFF with 8'h55 buffered -> next cycle all outputs are at reset values and no further shift_enable is issued; a new accept of 8'h81 then serializes correctly.
REQ-039 Chain the block to the downstream serial_to_parallel (shift_enable to shift_enable, serial_out to serial_in) and send words 8'h00, 8'hFF, 8'h3C -> after each frame_done the downstream data_out equals the sent word.
